// File: rtl/biestable_d_bank.sv
// Bank of N channels, each a DEPTH-deep shift register of W-bit words with a saturating fill count.
// Reads are combinational (zero latency); writes land on the rising edge; no backpressure, a load is accepted every cycle.
module biestable_d_bank #(
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 3,
    parameter logic [31:0] INI   = 32'd0,
    localparam int unsigned SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [W-1:0]  d,
    input  logic [SW-1:0] wsel,
    input  logic          load,
    input  logic          clr,
    input  logic [SW-1:0] rsel,
    output logic [W-1:0]  out_q,
    output logic [W-1:0]  out_old,
    output logic          full,
    output logic          changed
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [W-1:0] INI_W  = INI[W-1:0];
    localparam logic [SW:0]  N_EXT  = (SW + 1)'(N);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  stage [N][DEPTH];
    logic [CW-1:0] cnt   [N];

    logic wr_ok;
    logic rd_ok;

    // Indices at or beyond N are legal encodings when N is not a power of two (or N=1).
    assign wr_ok = load && ({1'b0, wsel} < N_EXT);
    assign rd_ok = ({1'b0, rsel} < N_EXT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage[i][k] <= INI_W;
                end
                cnt[i] <= '0;
            end
            changed <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage[i][k] <= INI_W;
                end
                cnt[i] <= '0;
            end
            changed <= 1'b0;
        end else begin
            changed <= wr_ok ? (d != stage[wsel][0]) : 1'b0;
            for (int i = 0; i < N; i++) begin
                if (wr_ok && (wsel == SW'(i))) begin
                    stage[i][0] <= d;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage[i][k] <= stage[i][k-1];
                    end
                    if (cnt[i] != DEPTH_C) begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        out_q   = '0;
        out_old = '0;
        full    = 1'b0;
        if (rd_ok) begin
            out_q   = stage[rsel][0];
            out_old = stage[rsel][DEPTH-1];
            full    = (cnt[rsel] == DEPTH_C);
        end
    end

endmodule
